// File: rtl/braid_mix_sequencer_if.sv
// Handshake/status bundle between the braid mix sequencer and its host and
// fluidic actuator layer.
//   master : sequencer side (drives mix requests and status, receives
//            start/abort/mix_ready)
//   slave  : host/actuator side (drives start/abort/mix_ready)
// Signals:
//   start, abort         host commands
//   mix_valid, mix_ready mixer request handshake
//   stage_idx, col_idx   coordinates of the current mixer
//   a_sel, b_sel         operand source columns in stage_idx+1
//   mixing, busy, done   sequence status, done is a one-cycle pulse
//   err                  sticky handshake-timeout flag
interface braid_mix_sequencer_if #(
    parameter int N_STAGES = 3,
    parameter int N_COLS   = 16,
    parameter int N_IN     = 3
);
    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int AW = $clog2(N_COLS + 1);
    localparam int BW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic          start;
    logic          abort;
    logic          mix_valid;
    logic          mix_ready;
    logic [SW-1:0] stage_idx;
    logic [CW-1:0] col_idx;
    logic [AW-1:0] a_sel;
    logic [BW-1:0] b_sel;
    logic          mixing;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  start, abort, mix_ready,
        output mix_valid, stage_idx, col_idx, a_sel, b_sel,
               mixing, busy, done, err
    );

    modport slave (
        output start, abort, mix_ready,
        input  mix_valid, stage_idx, col_idx, a_sel, b_sel,
               mixing, busy, done, err
    );
endinterface

// File: rtl/braid_mix_sequencer.sv
// Walks a braid of N_STAGES x N_COLS mixers, from the last stage down to
// stage 0 and column 0 upward within a stage. Each mixer is requested from the
// actuator layer with a valid/ready handshake and then timed for MIX_CYCLES
// clocks. A request that is not accepted within TIMEOUT cycles abandons the
// sequence and sets the sticky err flag.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  braid_mix_sequencer_if.master (commands, handshake, status)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// ISSUE  | mix_valid high, waiting for mix_ready (wait counter runs)
// MIX    | accepted mixer is timing its mix (mix counter counts down)
// DONE   | one-cycle done pulse, then back to IDLE
module braid_mix_sequencer #(
    parameter int N_STAGES   = 3,
    parameter int N_COLS     = 16,
    parameter int N_IN       = 3,
    parameter int MIX_CYCLES = 8,
    parameter int TIMEOUT    = 255
) (
    input logic                   clk,
    input logic                   rst,
    braid_mix_sequencer_if.master bus
);
    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int AW = $clog2(N_COLS + 1);
    localparam int BW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int MW = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] STAGE_LAST = SW'(N_STAGES - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(N_COLS - 1);
    localparam logic [BW-1:0] B_LAST     = BW'(N_IN - 1);
    localparam logic [BW-1:0] B_FIRST    = BW'(1);
    localparam logic [MW-1:0] MIX_LOAD   = MW'(MIX_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_MIX   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] stage_idx;
    logic [CW-1:0] col_idx;
    // b_idx tracks (col_idx+1) mod N_IN incrementally so no divider is needed.
    logic [BW-1:0] b_idx;
    logic [MW-1:0] mix_cnt;
    logic [TW-1:0] wait_cnt;
    logic          err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            stage_idx <= '0;
            col_idx   <= '0;
            b_idx     <= B_FIRST;
            mix_cnt   <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // abort is ignored here, so start+abort still starts.
                    if (bus.start) begin
                        state     <= S_ISSUE;
                        stage_idx <= STAGE_LAST;
                        col_idx   <= '0;
                        b_idx     <= B_FIRST;
                        wait_cnt  <= '0;
                        err       <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    // abort outranks both acceptance and timeout.
                    if (bus.abort) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else if (bus.mix_ready) begin
                        state    <= S_MIX;
                        mix_cnt  <= MIX_LOAD;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                S_MIX: begin
                    if (bus.abort) begin
                        state   <= S_IDLE;
                        mix_cnt <= '0;
                    end else if (mix_cnt != '0) begin
                        mix_cnt <= mix_cnt - MW'(1);
                    end else if (col_idx != COL_LAST) begin
                        state   <= S_ISSUE;
                        col_idx <= col_idx + CW'(1);
                        b_idx   <= (b_idx == B_LAST) ? '0 : b_idx + BW'(1);
                    end else if (stage_idx != '0) begin
                        state     <= S_ISSUE;
                        col_idx   <= '0;
                        b_idx     <= B_FIRST;
                        stage_idx <= stage_idx - SW'(1);
                    end else begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mix_valid = (state == S_ISSUE);
    assign bus.mixing    = (state == S_MIX);
    assign bus.busy      = (state == S_ISSUE) || (state == S_MIX);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err;
    assign bus.stage_idx = stage_idx;
    assign bus.col_idx   = col_idx;
    assign bus.a_sel     = AW'(col_idx) + AW'(1);
    assign bus.b_sel     = b_idx;
endmodule

// File: tb/tb_braid_mix_sequencer.sv
module tb_braid_mix_sequencer;
    localparam int NS  = 3;
    localparam int NC  = 16;
    localparam int NI  = 3;
    localparam int MC  = 8;
    localparam int LAT = NS * NC * (1 + MC) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    braid_mix_sequencer_if #(.N_STAGES(NS), .N_COLS(NC), .N_IN(NI)) bus0();
    braid_mix_sequencer_if #(.N_STAGES(NS), .N_COLS(NC), .N_IN(NI)) bus1();

    braid_mix_sequencer #(.N_STAGES(NS), .N_COLS(NC), .N_IN(NI),
                          .MIX_CYCLES(MC), .TIMEOUT(255))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    braid_mix_sequencer #(.N_STAGES(NS), .N_COLS(NC), .N_IN(NI),
                          .MIX_CYCLES(MC), .TIMEOUT(4))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int hs_cnt    = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_got;
    logic [31:0] mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every accepted handshake of dut0 is popped against
    // the expected mixer coordinates.
    always begin
        @(negedge clk);
        #1;
        if (!rst && bus0.mix_valid && bus0.mix_ready) begin
            mon_got = {8'(bus0.stage_idx), 8'(bus0.col_idx), 8'(bus0.a_sel), 8'(bus0.b_sel)};
            hs_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL handshake_unexpected got=%h expected=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL handshake_coords got=%h expected=%h", mon_got, mon_exp);
                end
            end
        end
        if (bus0.done) done0_cnt++;
        if (bus1.done) done1_cnt++;
    end

    task automatic push_run();
        for (int s = NS - 1; s >= 0; s--)
            for (int c = 0; c < NC; c++)
                exp_q.push_back({8'(s), 8'(c), 8'(c + 1), 8'((c + 1) % NI)});
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        bus0.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus0.done) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic check_run_end(input string name, input int t0, input int lat);
        int  at;
        bit  ok;
        wait_done(lat + 100, at, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_done_timeout got=none expected=done", name);
        end else begin
            checks++;
            if (at - t0 !== lat) begin
                failures++;
                $display("FAIL %s_latency got=%0d expected=%0d", name, at - t0, lat);
            end
            checks++;
            if (hs_cnt !== NS * NC || exp_q.size() !== 0) begin
                failures++;
                $display("FAIL %s_handshakes got=%0d left=%0d expected=%0d left=0",
                         name, hs_cnt, exp_q.size(), NS * NC);
            end
            @(negedge clk);
            checks++;
            if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
                failures++;
                $display("FAIL %s_done_pulse got=done%b busy%b expected=done0 busy0",
                         name, bus0.done, bus0.busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus0.mix_valid, bus0.mixing, bus0.busy, bus0.done, bus0.err} !== 5'b0 ||
            bus0.stage_idx !== 2'd0 || bus0.col_idx !== 4'd0 ||
            bus0.a_sel !== 5'd1 || bus0.b_sel !== 2'd1) begin
            failures++;
            $display("FAIL reset_dut0 got=v%b m%b b%b d%b e%b s%0d c%0d a%0d bs%0d expected=zeros a1 bs1",
                     bus0.mix_valid, bus0.mixing, bus0.busy, bus0.done, bus0.err,
                     bus0.stage_idx, bus0.col_idx, bus0.a_sel, bus0.b_sel);
        end
        checks++;
        if ({bus1.mix_valid, bus1.mixing, bus1.busy, bus1.done, bus1.err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_dut1 got=%b expected=00000",
                     {bus1.mix_valid, bus1.mixing, bus1.busy, bus1.done, bus1.err});
        end
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        int t0;
        bus0.mix_ready = 1'b1;
        exp_q.delete();
        push_run();
        hs_cnt = 0;
        pulse_start(t0);
        checks++;
        if (bus0.mix_valid !== 1'b1 || bus0.busy !== 1'b1) begin
            failures++;
            $display("FAIL full_first_issue got=v%b b%b expected=v1 b1", bus0.mix_valid, bus0.busy);
        end
        check_run_end("full", t0, LAT);
    endtask

    task automatic test_stall();
        int t0;
        bus0.mix_ready = 1'b0;
        exp_q.delete();
        push_run();
        hs_cnt = 0;
        pulse_start(t0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus0.mix_valid !== 1'b1 ||
                {8'(bus0.stage_idx), 8'(bus0.col_idx), 8'(bus0.a_sel), 8'(bus0.b_sel)} !== 32'h02000101) begin
                failures++;
                $display("FAIL stall_stable cycle=%0d got=v%b s%0d c%0d a%0d b%0d expected=v1 s2 c0 a1 b1",
                         i, bus0.mix_valid, bus0.stage_idx, bus0.col_idx, bus0.a_sel, bus0.b_sel);
            end
            @(negedge clk);
        end
        bus0.mix_ready = 1'b1;
        check_run_end("stall", t0, LAT + 5);
    endtask

    task automatic test_timeout();
        int d1;
        bus1.mix_ready = 1'b0;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        d1 = done1_cnt;
        repeat (3) @(negedge clk);
        checks++;
        if (bus1.err !== 1'b0 || bus1.busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early got=err%b busy%b expected=err0 busy1", bus1.err, bus1.busy);
        end
        @(negedge clk);
        checks++;
        if (bus1.err !== 1'b1 || bus1.busy !== 1'b0 || bus1.mix_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_hit got=err%b busy%b valid%b expected=err1 busy0 valid0",
                     bus1.err, bus1.busy, bus1.mix_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done1_cnt !== d1 || bus1.err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=dones%0d err%b expected=dones%0d err1",
                     done1_cnt - d1, bus1.err, 0);
        end
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        checks++;
        if (bus1.err !== 1'b0 || bus1.busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_clear got=err%b busy%b expected=err0 busy1", bus1.err, bus1.busy);
        end
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        checks++;
        if (bus1.busy !== 1'b0 || bus1.err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort got=busy%b err%b expected=busy0 err0", bus1.busy, bus1.err);
        end
    endtask

    task automatic test_abort();
        int t0;
        int d0;
        bit ok;
        bus0.mix_ready = 1'b1;
        exp_q.delete();
        push_run();
        hs_cnt = 0;
        pulse_start(t0);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bus0.mixing && bus0.stage_idx == 2'd1 && bus0.col_idx == 4'd7) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL abort_reach got=none expected=mix s1 c7");
        end
        bus0.abort = 1'b1;
        d0 = done0_cnt;
        @(negedge clk);
        bus0.abort = 1'b0;
        exp_q.delete();
        checks++;
        if (bus0.busy !== 1'b0 || bus0.mix_valid !== 1'b0 || bus0.mixing !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got=b%b v%b m%b expected=b0 v0 m0",
                     bus0.busy, bus0.mix_valid, bus0.mixing);
        end
        checks++;
        if (hs_cnt !== NC + 8) begin
            failures++;
            $display("FAIL abort_hs_count got=%0d expected=%0d", hs_cnt, NC + 8);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done0_cnt !== d0 || bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=dones%0d busy%b expected=dones0 busy0",
                     done0_cnt - d0, bus0.busy);
        end
        push_run();
        hs_cnt = 0;
        pulse_start(t0);
        checks++;
        if (bus0.mix_valid !== 1'b1 || bus0.stage_idx !== 2'd2 || bus0.col_idx !== 4'd0) begin
            failures++;
            $display("FAIL abort_restart got=v%b s%0d c%0d expected=v1 s2 c0",
                     bus0.mix_valid, bus0.stage_idx, bus0.col_idx);
        end
        check_run_end("restart", t0, LAT);
    endtask

    task automatic test_reset_mid();
        int t0;
        bit ok;
        bus0.mix_ready = 1'b1;
        exp_q.delete();
        push_run();
        hs_cnt = 0;
        pulse_start(t0);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bus0.mixing && bus0.col_idx == 4'd3) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_reach got=none expected=mix c3");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus0.mix_valid, bus0.mixing, bus0.busy, bus0.done, bus0.err} !== 5'b0 ||
            bus0.stage_idx !== 2'd0 || bus0.col_idx !== 4'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b s%0d c%0d expected=00000 s0 c0",
                     {bus0.mix_valid, bus0.mixing, bus0.busy, bus0.done, bus0.err},
                     bus0.stage_idx, bus0.col_idx);
        end
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_start_abort();
        int t0;
        bus0.mix_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_abort got=busy%b expected=busy0", bus0.busy);
        end
        push_run();
        hs_cnt = 0;
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        checks++;
        if (bus0.busy !== 1'b1 || bus0.stage_idx !== 2'd2 || bus0.col_idx !== 4'd0) begin
            failures++;
            $display("FAIL start_abort got=b%b s%0d c%0d expected=b1 s2 c0",
                     bus0.busy, bus0.stage_idx, bus0.col_idx);
        end
        check_run_end("start_abort", t0, LAT);
    endtask

    task automatic test_start_while_busy();
        int t0;
        bus0.mix_ready = 1'b1;
        exp_q.delete();
        push_run();
        hs_cnt = 0;
        pulse_start(t0);
        for (int k = 0; k < 4; k++) begin
            repeat (57 + 13 * k) @(negedge clk);
            bus0.start = 1'b1;
            @(negedge clk);
            bus0.start = 1'b0;
        end
        check_run_end("busy_start", t0, LAT);
    endtask

    initial begin
        rst = 1'b1;
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.mix_ready = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.mix_ready = 1'b0;
        test_reset();
        test_full_run();
        test_stall();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_start_abort();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/braid_mix_sequencer.md
BRAID_MIX_SEQUENCER -- requirements
Module: braid_mix_sequencer

Interface
REQ-001 Parameter N_STAGES, default 3: number of mixer stages in the braid.
REQ-002 Parameter N_COLS, default 16: mixers per stage.
REQ-003 Parameter N_IN, default 3: braid width (number of fluid inputs/outputs), ≥2.
REQ-004 Parameter MIX_CYCLES, default 8: mixing duration per mixer in clocks, ≥1.
REQ-005 Parameter TIMEOUT, default 255: maximum cycles waiting for mix_ready, ≥1.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 start  input  1  one-cycle request to run a full braid sequence.
REQ-009 abort  input  1  cancel the sequence in progress.
REQ-010 mix_valid  output  1  mixer operation request to the fluidic actuator layer.
REQ-011 mix_ready  input  1  actuator accepts the request.
REQ-012 stage_idx  output  clog2(N_STAGES)  stage of the current mixer.
REQ-013 col_idx  output  clog2(N_COLS)  column of the current mixer.
REQ-014 a_sel  output  clog2(N_COLS+1)  operand-a source column in stage_idx+1.
REQ-015 b_sel  output  clog2(N_IN)  operand-b source column in stage_idx+1.
REQ-016 mixing  output  1  high while the accepted mixer is timing its mix.
REQ-017 busy  output  1  sequence in progress.
REQ-018 done  output  1  one-cycle pulse on successful completion.
REQ-019 err  output  1  sticky handshake-timeout flag.

Function
REQ-020 The FSM SHALL use the states IDLE, ISSUE, MIX and DONE.
REQ-021 In IDLE, start=1 SHALL set stage_idx=N_STAGES-1 and col_idx=0, and move to ISSUE on the next edge; start outside IDLE SHALL be ignored.
REQ-022 Combinational outputs: mix_valid=1 only in ISSUE; mixing=1 only in MIX; busy=1 in ISSUE or MIX.
REQ-023 Operand selects: a_sel=col_idx+1; b_sel=(col_idx+1) mod N_IN.
REQ-024 stage_idx, col_idx, a_sel and b_sel SHALL stay stable while mix_valid=1 and mix_ready=0.
REQ-025 ISSUE with mix_ready=1 SHALL complete the handshake, load the mix counter with MIX_CYCLES-1, and enter MIX on the next edge.
REQ-026 Duration: MIX SHALL last exactly MIX_CYCLES cycles, counting down to 0.
REQ-027 Advance: at count 0 with col_idx<N_COLS-1, col_idx SHALL increment and the FSM SHALL go to ISSUE.
REQ-028 Stage change: at count 0 with col_idx=N_COLS-1 and stage_idx>0, col_idx SHALL wrap to 0, stage_idx SHALL decrement, and the FSM SHALL go to ISSUE.
REQ-029 Completion: at count 0 with col_idx=N_COLS-1 and stage_idx=0, the FSM SHALL go to DONE.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 Timeout: a wait counter SHALL run in ISSUE while mix_ready=0; on reaching TIMEOUT, err SHALL set and the FSM SHALL go to IDLE with no done.
REQ-032 err SHALL clear only on rst or on an accepted start.
REQ-033 abort=1 in ISSUE or MIX SHALL force IDLE on the next edge with no done; abort takes priority over handshake, advance and timeout in the same cycle.
REQ-034 abort in IDLE or DONE SHALL be ignored; DONE still pulses done.
REQ-035 Simultaneous start and abort in IDLE SHALL start the sequence.
REQ-036 Mixer count: total handshakes per sequence SHALL equal N_STAGES*N_COLS.
REQ-037 Latency: with mix_ready held 1, done SHALL occur N_STAGES*N_COLS*(1+MIX_CYCLES)+1 cycles after the start edge.

Reset
REQ-038 rst=1 SHALL force IDLE on the next edge regardless of state, including mid-handshake or mid-mix.
REQ-039 Reset values: mix_valid=0, mixing=0, busy=0, done=0, err=0, stage_idx=0, col_idx=0; mix and wait counters 0.

Verification
REQ-040 Defaults, start pulse, mix_ready=1 -> 48 handshakes; first (stage 2, col 0, a_sel 1, b_sel 1); col 2 has b_sel 0; last (stage 0, col 15, a_sel 16, b_sel 1); done at start+433.
REQ-041 mix_ready low 5 cycles at the first request -> outputs stable during the stall; acceptance on cycle 6; done delayed by exactly 5.
REQ-042 TIMEOUT=4, mix_ready stuck 0 -> err=1 after 4 wait cycles, busy=0, no done; next start clears err.
REQ-043 abort during the MIX of stage 1, col 7 -> IDLE next cycle, mix_valid=0, no done; a new start restarts at stage 2, col 0.
REQ-044 rst mid-MIX -> all outputs at reset values next cycle; start pulsed while busy -> no effect on sequence or timing.
